hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Keeps a shadow copy of the register-destination and control bits of each instruction as it moves from ID through EX, MEM and WB.
- From that state it drives the Forward_A/Forward_B selects of the EX stage, detects load-use hazards (stall plus bubble) and squashes younger instructions on a taken branch.
- Also keeps saturating stall and flush event counters for debug.

Parameters:
- REG_DIR_WIDTH, 3: register address width; register 0 is hardwired zero.
- CNT_WIDTH, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  the instruction in ID is real, not a bubble.
- id_rs  in  REG_DIR_WIDTH  rs field of the ID instruction.
- id_rt  in  REG_DIR_WIDTH  rt field of the ID instruction.
- id_uses_rs  in  1  the ID instruction reads rs.
- id_uses_rt  in  1  the ID instruction reads rt.
- id_WriteReg  in  REG_DIR_WIDTH  destination register of the ID instruction, already resolved by RegDst.
- id_RegWrite  in  1  the ID instruction writes the register file.
- id_MemRead  in  1  the ID instruction is a load.
- branch_taken  in  1  the branch in EX is resolved taken this cycle.
- Forward_A  out  2  EX operand A select: 0 = register file, 1 = WBData (MEM/WB), 2 = Address (EX/MEM).
- Forward_B  out  2  EX operand B select; same encoding as Forward_A.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEX_bubble  out  1  load control zeros into ID/EX.
- IFID_flush  out  1  clear IF/ID.
- stall_count  out  CNT_WIDTH  load-use stall cycles, saturating.
- flush_count  out  CNT_WIDTH  taken-branch flushes, saturating.

Behaviour:
- Shadow stages are EX, MEM and WB.
  - Each holds: v, rw (RegWrite), mr (MemRead), wr (WriteReg), rs, rt, urs, urt.
  - Every cycle: MEM<=EX and WB<=MEM.
  - EX<=ID inputs, except that EX.v<=0 when a bubble is inserted or reset is high.
  - The pipeline never freezes beyond ID, so MEM and WB always advance.
- Reset: all shadow v, rw and mr bits clear and both counters go to 0. While reset is high: Forward_A=Forward_B=0, PCWrite=1, IFIDWrite=1, IDEX_bubble=0, IFID_flush=0.
- Forwarding is combinational from registered shadow state, so its latency is 0 relative to the instruction in EX. For Forward_A:
  - 2 if MEM.v, MEM.rw, MEM.wr!=0 and MEM.wr==EX.rs, with EX.urs set.
  - Else 1 if the same condition holds for WB.
  - Else 0.
  - MEM has priority over WB: when both match, the output is 2 (newest value).
  - Forward_B is identical but uses EX.rt and EX.urt.
  - The value 3 is never driven.
- Load-use hazard (lu) = EX.v, EX.mr, EX.wr!=0 and id_valid, and either of:
  - id_uses_rs with EX.wr==id_rs;
  - id_uses_rt with EX.wr==id_rt.
- Stall on lu with no branch_taken:
  - PCWrite=0, IFIDWrite=0, IDEX_bubble=1.
  - Next cycle EX.v=0, so the load reaches MEM while the dependent instruction stays in ID.
  - Exactly one stall cycle occurs per load-use pair. On the following cycle the load is in MEM, not EX, so lu deasserts.
  - The dependent instruction then enters EX while the load is in WB and gets forward select 1.
- Flush on branch_taken:
  - IFID_flush=1, IDEX_bubble=1, PCWrite=1, IFIDWrite=1.
  - Next cycle EX.v=0.
- Simultaneous branch_taken and lu: the flush wins. There is no stall, because the dependent instruction is being squashed. stall_count does not increment and flush_count does.
- Counters increment by 1 on each cycle where the stall or flush condition holds. They hold at all-ones and do not wrap.
- Reset asserted mid-stall: the stall releases on the same cycle because outputs are gated by reset. Shadow state is empty on the first cycle after reset.
- Register 0 as a destination never forwards and never stalls.

Test Plan:
- Back-to-back dependency.
  - Stimulus: ID add r3 (rw=1, wr=3); next cycle ID sub with rs=3.
  - Required: when the sub is in EX, Forward_A=2; one cycle later, with a second consumer rt=3, Forward_B=1.
- Double write.
  - Stimulus: add r2 then or r2 back-to-back, then a consumer with rs=2.
  - Required: Forward_A=2, MEM priority over WB.
- Load-use.
  - Stimulus: lw r4 (mr=1, wr=4) followed by add with rt=4.
  - Required: exactly one cycle of PCWrite=0, IFIDWrite=0, IDEX_bubble=1.
  - Required: the add then enters EX with Forward_B=1, and stall_count=1.
- Taken branch.
  - Stimulus: branch_taken=1 for one cycle.
  - Required: IFID_flush=1, IDEX_bubble=1, PCWrite=1, next-cycle EX.v=0, flush_count=1.
- Branch and load-use together.
  - Stimulus: branch_taken=1 in the same cycle as a load-use.
  - Required: PCWrite=1, IFID_flush=1, stall_count unchanged.
- Reset and edge cases.
  - Stimulus: reset held for 2 cycles mid-stall, then a wr=0 load followed by a consumer of r0.
  - Required: all outputs at their reset values during reset.
  - Required: the r0 pair gives no stall and Forward_A=Forward_B=0.
  - Required: with CNT_WIDTH=2 and 5 stalls, stall_count=3.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl_if
// Brief    : ID-stage instruction fields in, forwarding/stall/flush controls out.
// Revision : 1.0
// ============================================================================
interface hazard_fwd_ctrl_if #(
    parameter int REG_DIR_WIDTH = 3,
    parameter int CNT_WIDTH     = 16
);
    logic                     id_valid;
    logic [REG_DIR_WIDTH-1:0] id_rs;
    logic [REG_DIR_WIDTH-1:0] id_rt;
    logic                     id_uses_rs;
    logic                     id_uses_rt;
    logic [REG_DIR_WIDTH-1:0] id_WriteReg;
    logic                     id_RegWrite;
    logic                     id_MemRead;
    logic                     branch_taken;
    logic [1:0]               Forward_A;
    logic [1:0]               Forward_B;
    logic                     PCWrite;
    logic                     IFIDWrite;
    logic                     IDEX_bubble;
    logic                     IFID_flush;
    logic [CNT_WIDTH-1:0]     stall_count;
    logic [CNT_WIDTH-1:0]     flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_WriteReg, id_RegWrite, id_MemRead, branch_taken,
        input  Forward_A, Forward_B, PCWrite, IFIDWrite, IDEX_bubble,
               IFID_flush, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_WriteReg, id_RegWrite, id_MemRead, branch_taken,
        output Forward_A, Forward_B, PCWrite, IFIDWrite, IDEX_bubble,
               IFID_flush, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Brief    : MIPS pipeline forwarding, load-use stall and branch flush control.
// Revision : 1.0
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_DIR_WIDTH = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_fwd_ctrl_if.slave bus
);
    localparam logic [1:0]           c_fwd_rf  = 2'd0;
    localparam logic [1:0]           c_fwd_wb  = 2'd1;
    localparam logic [1:0]           c_fwd_mem = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    // MEM/WB only need the fields that forwarding inspects.
    logic                     r_ex_v, r_ex_rw, r_ex_mr, r_ex_urs, r_ex_urt;
    logic [REG_DIR_WIDTH-1:0] r_ex_wr, r_ex_rs, r_ex_rt;
    logic                     r_mem_v, r_mem_rw;
    logic [REG_DIR_WIDTH-1:0] r_mem_wr;
    logic                     r_wb_v, r_wb_rw;
    logic [REG_DIR_WIDTH-1:0] r_wb_wr;
    logic [CNT_WIDTH-1:0]     r_stall_cnt, r_flush_cnt;

    logic w_mem_src, w_wb_src;
    logic w_lu, w_stall, w_flush;

    assign w_mem_src = r_mem_v & r_mem_rw & (r_mem_wr != '0);
    assign w_wb_src  = r_wb_v  & r_wb_rw  & (r_wb_wr  != '0);

    assign w_lu = r_ex_v & r_ex_mr & (r_ex_wr != '0) & bus.id_valid &
                  ((bus.id_uses_rs & (r_ex_wr == bus.id_rs)) |
                   (bus.id_uses_rt & (r_ex_wr == bus.id_rt)));

    // A taken branch squashes the dependent instruction, so it overrides the stall.
    assign w_flush = bus.branch_taken & ~reset;
    assign w_stall = w_lu & ~bus.branch_taken & ~reset;

    always_comb begin
        bus.Forward_A   = c_fwd_rf;
        bus.Forward_B   = c_fwd_rf;
        bus.PCWrite     = 1'b1;
        bus.IFIDWrite   = 1'b1;
        bus.IDEX_bubble = 1'b0;
        bus.IFID_flush  = 1'b0;
        if (!reset) begin
            if (r_ex_urs) begin
                if (w_mem_src && (r_mem_wr == r_ex_rs)) begin
                    bus.Forward_A = c_fwd_mem;
                end else if (w_wb_src && (r_wb_wr == r_ex_rs)) begin
                    bus.Forward_A = c_fwd_wb;
                end
            end
            if (r_ex_urt) begin
                if (w_mem_src && (r_mem_wr == r_ex_rt)) begin
                    bus.Forward_B = c_fwd_mem;
                end else if (w_wb_src && (r_wb_wr == r_ex_rt)) begin
                    bus.Forward_B = c_fwd_wb;
                end
            end
            bus.PCWrite     = ~w_stall;
            bus.IFIDWrite   = ~w_stall;
            bus.IDEX_bubble = w_stall | w_flush;
            bus.IFID_flush  = w_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_v      <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_ex_urs    <= 1'b0;
            r_ex_urt    <= 1'b0;
            r_ex_wr     <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_mem_v     <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_wr    <= '0;
            r_wb_v      <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_wr     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_ex_v   <= bus.id_valid & ~(w_stall | w_flush);
            r_ex_rw  <= bus.id_RegWrite;
            r_ex_mr  <= bus.id_MemRead;
            r_ex_urs <= bus.id_uses_rs;
            r_ex_urt <= bus.id_uses_rt;
            r_ex_wr  <= bus.id_WriteReg;
            r_ex_rs  <= bus.id_rs;
            r_ex_rt  <= bus.id_rt;
            r_mem_v  <= r_ex_v;
            r_mem_rw <= r_ex_rw;
            r_mem_wr <= r_ex_wr;
            r_wb_v   <= r_mem_v;
            r_wb_rw  <= r_mem_rw;
            r_wb_wr  <= r_mem_wr;
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign bus.stall_count = r_stall_cnt;
    assign bus.flush_count = r_flush_cnt;
endmodule
`default_nettype wire
